pipeline_ctrl: RTL and testbench

Pipeline control sequencer directly downstream of the hazard stall unit. Each cycle it consumes the 4-bit stall code together with the EXE-stage branch redirect and the MEM-stage exception request. From these it drives the write-enable and flush controls of the PC and the IF/ID, ID/EXE and EXE/MEM pipeline registers. It also runs a small FSM that masks in-flight exceptions after a trap, counts stall and flush events, and flags runaway stalls.

---
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline control sequencer: turns stall/redirect/trap requests into PC and
// pipeline-register enables and flushes, with a post-trap drain FSM and counters.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int STALL_LIMIT  = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       stall_C,
    input  logic             branch_taken_exe,
    input  logic             exc_req_mem,
    output logic             pc_we,
    output logic             pc_sel_exc,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             exe_mem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_timeout,
    output logic [1:0]       state_o
);

    // Stall unit encodings; every other code means no stall
    localparam logic [3:0] EXE_STALL = 4'b0100;
    localparam logic [3:0] MEM_STALL = 4'b1000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        REDIR = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [7:0]       run_q, run_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             timeout_q, timeout_d;

    logic exc_eff;
    logic stall;
    logic stall_app;
    logic in_drain;

    always_comb begin
        in_drain  = (state_q == DRAIN);
        exc_eff   = exc_req_mem && !in_drain;
        stall     = (stall_C == EXE_STALL) || (stall_C == MEM_STALL);
        stall_app = stall && !exc_eff && !branch_taken_exe;

        pc_we         = 1'b1;
        pc_sel_exc    = 1'b0;
        if_id_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        if (exc_eff) begin
            pc_sel_exc    = 1'b1;
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
        end else if (branch_taken_exe) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (stall) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_exe_flush = 1'b1;
        end
        // Younger instructions behind a trap must never reach MEM
        if (in_drain) begin
            exe_mem_flush = 1'b1;
        end

        drain_d = drain_q;
        if (exc_eff) begin
            state_d = DRAIN;
            drain_d = 4'(DRAIN_CYCLES - 1);
        end else if (in_drain && drain_q != 4'd0) begin
            state_d = DRAIN;
            drain_d = drain_q - 4'd1;
        end else if (branch_taken_exe) begin
            state_d = REDIR;
        end else if (stall) begin
            state_d = STALL;
        end else begin
            state_d = RUN;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_app && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if ((exc_eff || branch_taken_exe) && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end

        run_d = 8'd0;
        if (stall_app) begin
            run_d = (run_q == 8'(STALL_LIMIT)) ? run_q : run_q + 8'd1;
        end
        timeout_d = timeout_q || (run_d == 8'(STALL_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            drain_q     <= 4'd0;
            run_q       <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            run_q       <= run_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign stall_timeout = timeout_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus hand sequences for
// stall timeout, counter saturation and asynchronous reset mid-drain.
module tb_pipeline_ctrl;

    localparam logic [3:0] NS  = 4'b0000;
    localparam logic [3:0] EXE = 4'b0100;
    localparam logic [3:0] MEM = 4'b1000;

    // {pc_we, pc_sel_exc, if_id_we, if_id_flush, id_exe_flush, exe_mem_flush}
    localparam logic [5:0] C_RUN  = 6'b101000;
    localparam logic [5:0] C_STL  = 6'b000010;
    localparam logic [5:0] C_RED  = 6'b101110;
    localparam logic [5:0] C_TRP  = 6'b111111;
    localparam logic [5:0] C_DIDL = 6'b101001;
    localparam logic [5:0] C_DSTL = 6'b000011;
    localparam logic [5:0] C_DRED = 6'b101111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] stall_C;
    logic       branch_taken_exe;
    logic       exc_req_mem;
    logic       pc_we, pc_sel_exc, if_id_we;
    logic       if_id_flush, id_exe_flush, exe_mem_flush;
    logic [3:0] stall_cnt, flush_cnt;
    logic       stall_timeout;
    logic [1:0] state_o;

    pipeline_ctrl #(
        .DRAIN_CYCLES(2),
        .STALL_LIMIT (8),
        .CNT_W       (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_C         (stall_C),
        .branch_taken_exe(branch_taken_exe),
        .exc_req_mem     (exc_req_mem),
        .pc_we           (pc_we),
        .pc_sel_exc      (pc_sel_exc),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_exe_flush    (id_exe_flush),
        .exe_mem_flush   (exe_mem_flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .stall_timeout   (stall_timeout),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sc;
        logic       br;
        logic       exc;
        logic [5:0] ctl;
        logic [1:0] st;
        logic [3:0] scnt;
        logic [3:0] fcnt;
    } vec_t;

    vec_t vec[24];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5:0] ctl_now();
        return {pc_we, pc_sel_exc, if_id_we, if_id_flush, id_exe_flush, exe_mem_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sc, input logic br, input logic exc);
        stall_C          = sc;
        branch_taken_exe = br;
        exc_req_mem      = exc;
    endtask

    initial begin
        vec[0]  = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd0, 4'd0};
        vec[1]  = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd0, 4'd0};
        vec[2]  = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd0, 4'd0};
        vec[3]  = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd0, 4'd0};
        vec[4]  = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd0, 4'd0};
        vec[5]  = '{EXE, 1'b0, 1'b0, C_STL,  2'd1, 4'd1, 4'd0};
        vec[6]  = '{EXE, 1'b0, 1'b0, C_STL,  2'd1, 4'd2, 4'd0};
        vec[7]  = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd2, 4'd0};
        vec[8]  = '{4'hF, 1'b0, 1'b0, C_RUN, 2'd0, 4'd2, 4'd0};
        vec[9]  = '{4'h1, 1'b0, 1'b0, C_RUN, 2'd0, 4'd2, 4'd0};
        vec[10] = '{MEM, 1'b1, 1'b0, C_RED,  2'd2, 4'd2, 4'd1};
        vec[11] = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd2, 4'd1};
        vec[12] = '{MEM, 1'b0, 1'b0, C_STL,  2'd1, 4'd3, 4'd1};
        vec[13] = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd3, 4'd1};
        vec[14] = '{NS,  1'b0, 1'b1, C_TRP,  2'd3, 4'd3, 4'd2};
        vec[15] = '{NS,  1'b0, 1'b1, C_DIDL, 2'd3, 4'd3, 4'd2};
        vec[16] = '{NS,  1'b0, 1'b1, C_DIDL, 2'd0, 4'd3, 4'd2};
        vec[17] = '{NS,  1'b0, 1'b1, C_TRP,  2'd3, 4'd3, 4'd3};
        vec[18] = '{NS,  1'b0, 1'b0, C_DIDL, 2'd3, 4'd3, 4'd3};
        vec[19] = '{EXE, 1'b0, 1'b0, C_DSTL, 2'd1, 4'd4, 4'd3};
        vec[20] = '{MEM, 1'b1, 1'b1, C_TRP,  2'd3, 4'd4, 4'd4};
        vec[21] = '{NS,  1'b1, 1'b0, C_DRED, 2'd3, 4'd4, 4'd5};
        vec[22] = '{NS,  1'b0, 1'b0, C_DIDL, 2'd0, 4'd4, 4'd5};
        vec[23] = '{NS,  1'b0, 1'b0, C_RUN,  2'd0, 4'd4, 4'd5};

        rst = 1'b1;
        drive(NS, 1'b0, 1'b0);
        #1;
        chk("reset_ctl", 32'(ctl_now()), 32'(C_RUN));
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_scnt", 32'(stall_cnt), 32'd0);
        chk("reset_fcnt", 32'(flush_cnt), 32'd0);
        chk("reset_timeout", 32'(stall_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(vec[i].sc, vec[i].br, vec[i].exc);
            #1;
            chk($sformatf("v%0d_ctl", i), 32'(ctl_now()), 32'(vec[i].ctl));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_state", i), 32'(state_o), 32'(vec[i].st));
            chk($sformatf("v%0d_scnt", i), 32'(stall_cnt), 32'(vec[i].scnt));
            chk($sformatf("v%0d_fcnt", i), 32'(flush_cnt), 32'(vec[i].fcnt));
            chk($sformatf("v%0d_timeout", i), 32'(stall_timeout), 32'd0);
        end

        // Runaway stall: flag sets on the 8th consecutive stall edge
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(EXE, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            if (i == 6) chk("timeout_after7", 32'(stall_timeout), 32'd0);
            if (i == 7) chk("timeout_after8", 32'(stall_timeout), 32'd1);
        end
        chk("scnt_after_run", 32'(stall_cnt), 32'd12);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(NS, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("timeout_sticky", 32'(stall_timeout), 32'd1);
        chk("state_idle", 32'(state_o), 32'd0);

        // Saturation of the 4-bit stall counter
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(MEM, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            if (i == 2) chk("scnt_reach_max", 32'(stall_cnt), 32'd15);
        end
        chk("scnt_saturated", 32'(stall_cnt), 32'd15);

        // Asynchronous reset between edges clears the sticky flag
        @(negedge clk);
        drive(NS, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst1_timeout", 32'(stall_timeout), 32'd0);
        chk("arst1_scnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(EXE, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        drive(NS, 1'b0, 1'b1);
        #1;
        chk("pre_rst_trap_ctl", 32'(ctl_now()), 32'(C_TRP));
        @(negedge clk);
        drive(NS, 1'b0, 1'b0);
        #1;
        chk("mid_drain_ctl", 32'(ctl_now()), 32'(C_DIDL));
        chk("mid_drain_state", 32'(state_o), 32'd3);
        chk("mid_drain_scnt", 32'(stall_cnt), 32'd3);
        rst = 1'b1;
        #1;
        chk("arst2_ctl", 32'(ctl_now()), 32'(C_RUN));
        chk("arst2_state", 32'(state_o), 32'd0);
        chk("arst2_scnt", 32'(stall_cnt), 32'd0);
        chk("arst2_fcnt", 32'(flush_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_state", 32'(state_o), 32'd0);
        chk("post_rst_ctl", 32'(ctl_now()), 32'(C_RUN));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
